// File: rtl/uart_line_rx.sv
// Line assembler downstream of the UART receiver: collects bytes into a buffer, applies backspace, hands off completed lines.
// Latency: a byte is reflected in line_len/buffer the cycle after acceptance; rd_data has 1-cycle read latency.
// Backpressure: rx_data_ready is high only while collecting; it drops for a held line until line_ack.
module uart_line_rx #(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_data_valid,
    output logic              rx_data_ready,
    output logic              line_valid,
    output logic [ADDR_W:0]   line_len,
    output logic              line_ovf,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_data,
    input  logic              line_ack
);

    typedef enum logic [0:0] {
        ST_COLLECT = 1'b0,
        ST_DONE    = 1'b1
    } state_t;

    localparam logic [ADDR_W:0] LEN_FULL = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] LEN_ONE  = (ADDR_W+1)'(1);

    localparam logic [7:0] CH_CR  = 8'h0D;
    localparam logic [7:0] CH_LF  = 8'h0A;
    localparam logic [7:0] CH_BS  = 8'h08;
    localparam logic [7:0] CH_DEL = 8'h7F;

    state_t            state_q, state_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic              ovf_q, ovf_d;
    logic [7:0]        rd_data_q, rd_data_d;

    // Line storage; deliberately never reset or cleared, only bytes below line_len are meaningful.
    logic [7:0]        buf_q [DEPTH];

    logic              accept;
    logic              is_term;
    logic              is_bs;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;

    // Byte classification and handshake; ready comes from the state register alone.
    always_comb begin
        is_term = (rx_data == CH_CR) || (rx_data == CH_LF);
        is_bs   = (rx_data == CH_BS) || (rx_data == CH_DEL);
        accept  = rx_data_valid && (state_q == ST_COLLECT);
    end

    // Next-state, length/overflow update and buffer write decode.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        ovf_d   = ovf_q;
        wr_en   = 1'b0;
        wr_addr = len_q[ADDR_W-1:0];
        case (state_q)
            ST_COLLECT: begin
                if (accept) begin
                    if (is_term) begin
                        // Terminators on an empty line are swallowed so CR LF never yields a blank line.
                        if (len_q != '0) begin
                            state_d = ST_DONE;
                        end
                    end else if (is_bs) begin
                        if (len_q != '0) begin
                            len_d = len_q - LEN_ONE;
                        end
                    end else if (len_q != LEN_FULL) begin
                        wr_en = 1'b1;
                        len_d = len_q + LEN_ONE;
                    end else begin
                        // Buffer full: drop the byte and remember it; backspace does not clear this.
                        ovf_d = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                if (line_ack) begin
                    state_d = ST_COLLECT;
                    len_d   = '0;
                    ovf_d   = 1'b0;
                end
            end
            default: begin
                state_d = ST_COLLECT;
                len_d   = '0;
                ovf_d   = 1'b0;
            end
        endcase
    end

    // Registered read port, usable in any state.
    always_comb begin
        rd_data_d = buf_q[rd_addr];
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_COLLECT;
            len_q     <= '0;
            ovf_q     <= 1'b0;
            rd_data_q <= 8'h00;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            ovf_q     <= ovf_d;
            rd_data_q <= rd_data_d;
        end
    end

    // Buffer write; no reset so contents survive reset and ack.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            buf_q[wr_addr] <= rx_data;
        end
    end

    assign rx_data_ready = (state_q == ST_COLLECT);
    assign line_valid    = (state_q == ST_DONE);
    assign line_len      = len_q;
    assign line_ovf      = ovf_q;
    assign rd_data       = rd_data_q;

endmodule
